// File: rtl/rv32_pipe_pkg.sv
// Shared definitions for the RV32IM pipeline front end: data width, reset
// defaults and the fetch-stage enums.
package rv32_pipe_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_NOP_INSTR    = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    // Fetch FSM: FETCH issues real reads, DISCARD waits out a wrong-path read
    typedef enum logic [0:0] {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_e;

    // Next-PC source selector for the pc_register
    typedef enum logic [1:0] {
        PC_HOLD    = 2'd0,
        PC_INC     = 2'd1,
        PC_BRANCH  = 2'd2,
        PC_PENDING = 2'd3
    } pc_sel_e;

    // Force word alignment on an address
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_fetch_unit_pc_register.sv
// Program-counter register with its next-PC mux. Exposes the current PC and
// PC+4 (modulo 2^32) to the fetch stage.
module pc_register
    import rv32_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
    input  logic            clk,
    input  logic            reset,
    input  pc_sel_e         pc_sel,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] pending_target,
    output logic [XLEN-1:0] pc_reg,
    output logic [XLEN-1:0] pc_reg_plus_4
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_inc_s;

    assign pc_inc_s = pc_q + PC_STEP;

    // Select the next PC: hold, sequential step, fresh redirect or deferred redirect
    always_comb begin
        pc_d = pc_q;
        case (pc_sel)
            PC_HOLD:    pc_d = pc_q;
            PC_INC:     pc_d = pc_inc_s;
            PC_BRANCH:  pc_d = align_word(branch_target);
            PC_PENDING: pc_d = align_word(pending_target);
            default:    pc_d = pc_q;
        endcase
    end

    // PC state register with synchronous reset to the reset vector
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_reg        = pc_q;
    assign pc_reg_plus_4 = pc_inc_s;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues reads to a multi-cycle
// instruction memory, and presents registered INSTRUCTION/PC/PC_PLUS_4 to the
// IF/ID register. Stalls hold the outputs; redirects flush and, when a read
// is already in flight, wait it out in DISCARD before fetching the target.
module if_fetch_unit
    import rv32_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [XLEN-1:0] NOP_INSTR    = DEF_NOP_INSTR
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            STALL,
    input  logic            BRANCH_TAKEN,
    input  logic [XLEN-1:0] BRANCH_TARGET,
    output logic            IMEM_READ,
    output logic [XLEN-1:0] IMEM_ADDRESS,
    input  logic [XLEN-1:0] IMEM_READDATA,
    input  logic            IMEM_BUSY,
    output logic [XLEN-1:0] INSTRUCTION,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC_PLUS_4,
    output logic            FETCH_VALID
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] pending_target_q;
    logic [XLEN-1:0] pending_target_d;
    pc_sel_e         pc_sel_s;

    logic [XLEN-1:0] pc_reg_s;
    logic [XLEN-1:0] pc_reg_plus_4_s;

    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_d;
    logic [XLEN-1:0] pc_out_q;
    logic [XLEN-1:0] pc_out_d;
    logic [XLEN-1:0] pc_plus_4_q;
    logic [XLEN-1:0] pc_plus_4_d;
    logic            valid_q;
    logic            valid_d;

    pc_register #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_register (
        .clk            (CLK),
        .reset          (RESET),
        .pc_sel         (pc_sel_s),
        .branch_target  (BRANCH_TARGET),
        .pending_target (pending_target_q),
        .pc_reg         (pc_reg_s),
        .pc_reg_plus_4  (pc_reg_plus_4_s)
    );

    // The read is always outstanding outside reset; the address only moves
    // on completion or an unblocked redirect, so it is stable while busy
    assign IMEM_READ    = ~RESET;
    assign IMEM_ADDRESS = pc_reg_s;

    // FSM state and deferred-redirect target register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q          <= FETCH;
            pending_target_q <= 32'h0000_0000;
        end else begin
            state_q          <= state_d;
            pending_target_q <= pending_target_d;
        end
    end

    // Next-state logic: FSM transition, pending target and next-PC source
    always_comb begin
        state_d          = state_q;
        pending_target_d = pending_target_q;
        pc_sel_s         = PC_HOLD;
        case (state_q)
            FETCH: begin
                if (BRANCH_TAKEN) begin
                    if (IMEM_BUSY) begin
                        // Read in flight: keep the address, remember the target
                        pending_target_d = align_word(BRANCH_TARGET);
                        state_d          = DISCARD;
                    end else begin
                        pc_sel_s = PC_BRANCH;
                    end
                end else if (!IMEM_BUSY && !STALL) begin
                    pc_sel_s = PC_INC;
                end else begin
                    pc_sel_s = PC_HOLD;
                end
            end
            DISCARD: begin
                if (BRANCH_TAKEN) begin
                    // Latest redirect wins
                    pending_target_d = align_word(BRANCH_TARGET);
                    if (!IMEM_BUSY) begin
                        pc_sel_s = PC_BRANCH;
                        state_d  = FETCH;
                    end else begin
                        state_d = DISCARD;
                    end
                end else if (!IMEM_BUSY) begin
                    // Wrong-path read done: drop the data, fetch the target.
                    // Taken even under stall so FETCH never resumes on the old path.
                    pc_sel_s = PC_PENDING;
                    state_d  = FETCH;
                end else begin
                    state_d = DISCARD;
                end
            end
            default: begin
                state_d  = FETCH;
                pc_sel_s = PC_HOLD;
            end
        endcase
    end

    // Output logic: flush on redirect, hold on stall, capture on completion,
    // otherwise present a bubble with PC/PC_PLUS_4 held
    always_comb begin
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        pc_plus_4_d = pc_plus_4_q;
        valid_d     = valid_q;
        if (BRANCH_TAKEN) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (STALL) begin
            instr_d = instr_q;
            valid_d = valid_q;
        end else if ((state_q == FETCH) && !IMEM_BUSY) begin
            instr_d     = IMEM_READDATA;
            pc_out_d    = pc_reg_s;
            pc_plus_4_d = pc_reg_plus_4_s;
            valid_d     = 1'b1;
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    // IF/ID-facing output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            instr_q     <= NOP_INSTR;
            pc_out_q    <= 32'h0000_0000;
            pc_plus_4_q <= 32'h0000_0000;
            valid_q     <= 1'b0;
        end else begin
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
            pc_plus_4_q <= pc_plus_4_d;
            valid_q     <= valid_d;
        end
    end

    assign INSTRUCTION = instr_q;
    assign PC          = pc_out_q;
    assign PC_PLUS_4   = pc_plus_4_q;
    assign FETCH_VALID = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit with hand-computed expectations.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK;
    logic        RESET;
    logic        STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSY;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC;
    logic [31:0] PC_PLUS_4;
    logic        FETCH_VALID;

    int checks_cnt;
    int fail_cnt;

    if_fetch_unit dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .STALL         (STALL),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .IMEM_READ     (IMEM_READ),
        .IMEM_ADDRESS  (IMEM_ADDRESS),
        .IMEM_READDATA (IMEM_READDATA),
        .IMEM_BUSY     (IMEM_BUSY),
        .INSTRUCTION   (INSTRUCTION),
        .PC            (PC),
        .PC_PLUS_4     (PC_PLUS_4),
        .FETCH_VALID   (FETCH_VALID)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, then sample 1 unit after the rising edge
    task automatic cyc(input logic stall, input logic br, input logic [31:0] tgt,
                       input logic busy, input logic [31:0] rdata);
        STALL         = stall;
        BRANCH_TAKEN  = br;
        BRANCH_TARGET = tgt;
        IMEM_BUSY     = busy;
        IMEM_READDATA = rdata;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] pc4, input logic valid, input logic [31:0] addr);
        check_eq({tag, ".instr"}, INSTRUCTION, instr);
        check_eq({tag, ".pc"}, PC, pc);
        check_eq({tag, ".pc4"}, PC_PLUS_4, pc4);
        check_eq({tag, ".valid"}, {31'd0, FETCH_VALID}, {31'd0, valid});
        check_eq({tag, ".addr"}, IMEM_ADDRESS, addr);
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        RESET      = 1'b1;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk_all("reset", NOP, 32'h0, 32'h0, 1'b0, 32'h0);
        check_eq("reset.read", {31'd0, IMEM_READ}, 32'd0);
        RESET = 1'b0;
        #1;
        check_eq("run.read", {31'd0, IMEM_READ}, 32'd1);

        // Back-to-back completions
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0050_0093);
        chk_all("c0", 32'h0050_0093, 32'h0, 32'h4, 1'b1, 32'h4);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h1111_1111);
        chk_all("c1", 32'h1111_1111, 32'h4, 32'h8, 1'b1, 32'h8);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h2222_2222);
        chk_all("c2", 32'h2222_2222, 32'h8, 32'hC, 1'b1, 32'hC);

        // Stall holds outputs and PC_REG; returned data ignored
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h3333_3333);
        chk_all("st0", 32'h2222_2222, 32'h8, 32'hC, 1'b1, 32'hC);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h3333_3333);
        chk_all("st1", 32'h2222_2222, 32'h8, 32'hC, 1'b1, 32'hC);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h3333_3333);
        chk_all("st_rel", 32'h3333_3333, 32'hC, 32'h10, 1'b1, 32'h10);

        // Busy memory: bubbles, address stable, PC held
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0_0000);
            chk_all("busy", NOP, 32'hC, 32'h10, 1'b0, 32'h10);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h4444_4444);
        chk_all("busy_done", 32'h4444_4444, 32'h10, 32'h14, 1'b1, 32'h14);

        // Redirect with simultaneous stall and completion, low bits masked
        cyc(1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'hBAD1_1111);
        chk_all("br0", NOP, 32'h10, 32'h14, 1'b0, 32'h100);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h5555_5555);
        chk_all("br0_tgt", 32'h5555_5555, 32'h100, 32'h104, 1'b1, 32'h104);

        // Redirect while busy: DISCARD, wrong-path data dropped
        cyc(1'b0, 1'b1, 32'h0000_0200, 1'b1, 32'hBAD2_2222);
        chk_all("br1", NOP, 32'h100, 32'h104, 1'b0, 32'h104);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD2_2222);
        chk_all("disc_busy", NOP, 32'h100, 32'h104, 1'b0, 32'h104);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF);
        chk_all("disc_drop", NOP, 32'h100, 32'h104, 1'b0, 32'h200);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h6666_6666);
        chk_all("br1_tgt", 32'h6666_6666, 32'h200, 32'h204, 1'b1, 32'h204);

        // Second redirect during DISCARD overrides the first
        cyc(1'b0, 1'b1, 32'h0000_0280, 1'b1, 32'hBAD3_3333);
        cyc(1'b0, 1'b1, 32'h0000_0300, 1'b1, 32'hBAD3_3333);
        chk_all("br2", NOP, 32'h200, 32'h204, 1'b0, 32'h204);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'hBAD3_3333);
        chk_all("br2_drop", NOP, 32'h200, 32'h204, 1'b0, 32'h300);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h7777_7777);
        chk_all("br2_tgt", 32'h7777_7777, 32'h300, 32'h304, 1'b1, 32'h304);

        // Redirect in DISCARD with BUSY=0 goes straight to the new target
        cyc(1'b0, 1'b1, 32'h0000_0400, 1'b1, 32'hBAD4_4444);
        cyc(1'b0, 1'b1, 32'h0000_0500, 1'b0, 32'hBAD4_4444);
        chk_all("br3", NOP, 32'h300, 32'h304, 1'b0, 32'h500);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h8888_8888);
        chk_all("br3_tgt", 32'h8888_8888, 32'h500, 32'h504, 1'b1, 32'h504);

        // Wrap-around at the top of the address space
        cyc(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'hBAD5_5555);
        chk_all("wrap_br", NOP, 32'h500, 32'h504, 1'b0, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h9999_9999);
        chk_all("wrap", 32'h9999_9999, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0);

        // Reset in the middle of a busy read
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD6_6666);
        RESET = 1'b1;
        #1;
        check_eq("rst_mid.read", {31'd0, IMEM_READ}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD6_6666);
        chk_all("rst_mid", NOP, 32'h0, 32'h0, 1'b0, 32'h0);
        RESET = 1'b0;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h1234_5678);
        chk_all("post_rst", 32'h1234_5678, 32'h0, 32'h4, 1'b1, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
